// File: rtl/arbitro_pkg.sv
// Shared constants for the button arbiter: FSM state encoding and the
// default timing values for the 50 MHz board clock.
package arbitro_pkg;

  localparam logic [1:0] ST_OCIOSO = 2'd0;
  localparam logic [1:0] ST_OFERTA = 2'd1;
  localparam logic [1:0] ST_ESPERA = 2'd2;

  // 50000 cycles at 50 MHz = 1 ms hold to count as a long press
  localparam int LONG_CICLOS_DEF = 50000;
  // 1000 cycles at 50 MHz = 20 us of silence after each accepted event
  localparam int COOLDOWN_DEF    = 1000;

endpackage

// File: rtl/arbitro_botoes_if.sv
// Event handshake between the arbiter (master) and the game FSM (slave).
interface arbitro_botoes_if #(
  parameter int W_ID = 2
) ();

  logic            evt_valid;
  logic            evt_ready;
  logic [W_ID-1:0] evt_id;
  logic            evt_longo;

  modport master (output evt_valid, output evt_id, output evt_longo, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_longo, output evt_ready);

endinterface

// File: rtl/detector_pressao.sv
// Per-button press detector: registers the debounced level, counts how long
// it is held and emits one-cycle short/long event pulses.
module detector_pressao #(
  parameter int W_CNT       = 16,
  parameter int LONG_CICLOS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao_in,
  output logic b_q,
  output logic ev_curto,
  output logic ev_longo
);

  localparam logic [W_CNT-1:0] LIMITE    = W_CNT'(LONG_CICLOS);
  localparam logic [W_CNT-1:0] LIMITE_M1 = W_CNT'(LONG_CICLOS - 1);

  logic [W_CNT-1:0] cnt;

  // Input register plus hold counter that saturates at the long threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q <= 1'b0;
      cnt <= '0;
    end else begin
      b_q <= botao_in;
      if (!b_q)
        cnt <= '0;
      else if (cnt != LIMITE)
        cnt <= cnt + 1'b1;
    end
  end

  // Long fires as the counter steps onto the threshold; short fires in the
  // cycle after b_q falls, while the counter still holds the press length
  always_comb begin
    ev_longo = b_q && (cnt == LIMITE_M1);
    ev_curto = !b_q && (cnt != '0) && (cnt < LIMITE);
  end

endmodule

// File: rtl/arbitro_botoes.sv
// Button arbiter: turns N debounced buttons into single short/long events,
// keeps one pending event per button and serves them round-robin through a
// valid/ready handshake with a cooldown after every accepted event.
module arbitro_botoes
  import arbitro_pkg::*;
#(
  parameter int N_BOTOES    = 3,
  parameter int W_CNT       = 16,
  parameter int LONG_CICLOS = LONG_CICLOS_DEF,
  parameter int COOLDOWN    = COOLDOWN_DEF,
  parameter int W_ID        = $clog2(N_BOTOES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BOTOES-1:0] botoes_in,
  output logic                ocupado,
  arbitro_botoes_if.master    evt
);

  localparam int W_CD = $clog2(COOLDOWN + 2);

  logic [N_BOTOES-1:0] b_q;
  logic [N_BOTOES-1:0] ev_curto;
  logic [N_BOTOES-1:0] ev_longo;
  logic [N_BOTOES-1:0] ev_any;
  logic [N_BOTOES-1:0] pend;
  logic [N_BOTOES-1:0] pend_longo;
  logic [N_BOTOES-1:0] clr_mask;

  logic [1:0]      state;
  logic [W_ID-1:0] rr;
  logic [W_ID-1:0] id_q;
  logic            longo_q;
  logic            valid_q;
  logic [W_CD-1:0] cd;

  logic            gnt_any;
  logic [W_ID-1:0] gnt_id;
  logic            grant;
  int              idx;

  genvar g;
  generate
    for (g = 0; g < N_BOTOES; g++) begin : g_det
      detector_pressao #(
        .W_CNT      (W_CNT),
        .LONG_CICLOS(LONG_CICLOS)
      ) u_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .botao_in(botoes_in[g]),
        .b_q     (b_q[g]),
        .ev_curto(ev_curto[g]),
        .ev_longo(ev_longo[g])
      );
    end
  endgenerate

  assign ocupado       = |b_q;
  assign ev_any        = ev_curto | ev_longo;
  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
  assign evt.evt_longo = longo_q;

  // Round-robin pick: first pending button searching upward from rr+1
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 1; k <= N_BOTOES; k++) begin
      idx = (int'(rr) + k) % N_BOTOES;
      if (!gnt_any && pend[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = W_ID'(idx);
      end
    end
    grant    = (state == ST_OCIOSO) && gnt_any;
    clr_mask = '0;
    if (grant)
      clr_mask[gnt_id] = 1'b1;
  end

  // Pending flags: a new event always wins over the grant's clear and
  // overwrites the stored short/long kind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      pend_longo <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | ev_any;
      for (int i = 0; i < N_BOTOES; i++)
        if (ev_any[i])
          pend_longo[i] <= ev_longo[i];
    end
  end

  // Offer FSM: grant from idle, hold the offer until accepted, then cool down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OCIOSO;
      valid_q <= 1'b0;
      id_q    <= '0;
      longo_q <= 1'b0;
      rr      <= W_ID'(N_BOTOES - 1);
      cd      <= '0;
    end else begin
      case (state)
        ST_OCIOSO: begin
          if (gnt_any) begin
            id_q    <= gnt_id;
            longo_q <= pend_longo[gnt_id];
            valid_q <= 1'b1;
            state   <= ST_OFERTA;
          end
        end
        ST_OFERTA: begin
          if (evt.evt_ready) begin
            valid_q <= 1'b0;
            rr      <= id_q;
            cd      <= W_CD'(COOLDOWN);
            state   <= (COOLDOWN > 0) ? ST_ESPERA : ST_OCIOSO;
          end
        end
        ST_ESPERA: begin
          cd <= cd - 1'b1;
          if (cd == W_CD'(1))
            state <= ST_OCIOSO;
        end
        default: begin
          state <= ST_OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_botoes.sv
// Scoreboard bench for arbitro_botoes: stimulus pushes the expected events
// (derived from press length and round-robin order) and a monitor pops and
// compares them at every accepted handshake.
module tb_arbitro_botoes;

  localparam int N    = 3;
  localparam int LONG = 8;
  localparam int CD   = 4;
  localparam int WID  = 2;

  typedef struct packed {
    logic [WID-1:0] id;
    logic           longo;
  } evt_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] botoes_in = '0;
  logic         ocupado;

  arbitro_botoes_if #(.W_ID(WID)) evt ();

  arbitro_botoes #(
    .N_BOTOES   (N),
    .W_CNT      (16),
    .LONG_CICLOS(LONG),
    .COOLDOWN   (CD),
    .W_ID       (WID)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .botoes_in(botoes_in),
    .ocupado  (ocupado),
    .evt      (evt)
  );

  always #5 clk = ~clk;

  evt_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_rr = N - 1;
  bit   rnd_ready_en = 1'b0;

  int             low_run = 0;
  int             gap_at_offer = 0;
  logic           prev_valid = 1'b0;
  logic           prev_acc = 1'b0;
  logic [WID-1:0] held_id = '0;
  logic           held_longo = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected order for buttons whose events appear together: cyclic from rr+1
  task automatic push_events(input logic [N-1:0] mask, input bit longo);
    evt_t e;
    int   last;
    last = model_rr;
    for (int k = 1; k <= N; k++) begin
      int b;
      b = (model_rr + k) % N;
      if (mask[b]) begin
        e.id    = WID'(b);
        e.longo = longo;
        exp_q.push_back(e);
        last = b;
      end
    end
    model_rr = last;
  endtask

  task automatic press(input logic [N-1:0] mask, input int d);
    botoes_in = botoes_in | mask;
    repeat (d) tick();
    botoes_in = botoes_in & ~mask;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (CD + 3) tick();
  endtask

  // Random consumer back-pressure when enabled
  always @(posedge clk) begin
    if (rnd_ready_en) begin
      #1;
      evt.evt_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares accepted events, offer stability and idle gaps
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
      low_run    = 0;
    end else begin
      if (evt.evt_valid) begin
        if (!prev_valid)
          gap_at_offer = low_run;
        if (prev_valid && !prev_acc) begin
          check("stable_id", evt.evt_id, held_id);
          check("stable_longo", evt.evt_longo, held_longo);
        end
        held_id    = evt.evt_id;
        held_longo = evt.evt_longo;
        if (evt.evt_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_event id=%0d longo=%0d required=none",
                     evt.evt_id, evt.evt_longo);
          end else begin
            evt_t e;
            e = exp_q.pop_front();
            check("evt_id", evt.evt_id, e.id);
            check("evt_longo", evt.evt_longo, e.longo);
          end
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_valid = evt.evt_valid;
      prev_acc   = evt.evt_valid & evt.evt_ready;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    evt.evt_ready = 1'b0;

    // Reset with arbitrary inputs
    botoes_in     = N'($urandom_range(1, 7));
    evt.evt_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", evt.evt_valid, 0);
    check("rst_id", evt.evt_id, 0);
    check("rst_longo", evt.evt_longo, 0);
    check("rst_ocupado", ocupado, 0);
    botoes_in = '0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Simultaneous release of 0 and 2, twice: rr wraps so 0 comes first
    for (int r = 0; r < 2; r++) begin
      push_events(3'b101, 1'b0);
      press(3'b101, 3);
      wait_drain(100);
      check("cooldown_gap", gap_at_offer, CD + 1);
    end

    // Short press on button 1 with exact latency and one-cycle pulse
    botoes_in[1] = 1'b1;
    tick();
    check("ocupado_press", ocupado, 1);
    repeat (2) tick();
    botoes_in[1] = 1'b0;
    push_events(3'b010, 1'b0);
    tick();
    check("ocupado_release", ocupado, 0);
    check("short_lat_e1", evt.evt_valid, 0);
    tick();
    check("short_lat_e2", evt.evt_valid, 0);
    tick();
    check("short_lat_e3", evt.evt_valid, 1);
    check("short_id", evt.evt_id, 1);
    check("short_longo", evt.evt_longo, 0);
    tick();
    check("short_pulse", evt.evt_valid, 0);
    wait_drain(50);

    // Long press on button 0 held 20 cycles, nothing on release
    botoes_in[0] = 1'b1;
    push_events(3'b001, 1'b1);
    repeat (9) tick();
    check("long_lat_pre", evt.evt_valid, 0);
    tick();
    check("long_lat", evt.evt_valid, 1);
    check("long_id", evt.evt_id, 0);
    check("long_longo", evt.evt_longo, 1);
    repeat (10) tick();
    botoes_in[0] = 1'b0;
    repeat (15) tick();
    wait_drain(50);

    // Stalled offer on button 1 while it is pressed short, then long again
    evt.evt_ready = 1'b0;
    push_events(3'b010, 1'b0);
    press(3'b010, 3);
    repeat (3) tick();
    check("stall_valid", evt.evt_valid, 1);
    check("stall_id", evt.evt_id, 1);
    press(3'b010, 2);
    repeat (3) tick();
    press(3'b010, 10);
    repeat (4) tick();
    check("stall_valid_hold", evt.evt_valid, 1);
    check("stall_longo_hold", evt.evt_longo, 0);
    exp_q.push_back('{id: WID'(1), longo: 1'b1});
    model_rr = 1;
    evt.evt_ready = 1'b1;
    wait_drain(100);

    // Randomized single and simultaneous presses under random back-pressure
    rnd_ready_en = 1'b1;
    for (int it = 0; it < 16; it++) begin
      logic [N-1:0] mask;
      int           d;
      mask = N'($urandom_range(1, 7));
      if ($urandom_range(0, 1) == 1)
        mask = N'(1 << $urandom_range(0, N - 1));
      d = (it == 0) ? LONG - 1 : (it == 1) ? LONG : $urandom_range(1, 12);
      push_events(mask, d >= LONG);
      press(mask, d);
      wait_drain(300);
    end
    rnd_ready_en = 1'b0;
    tick();

    // Asynchronous reset during an offer with another event pending
    evt.evt_ready = 1'b0;
    push_events(3'b100, 1'b0);
    press(3'b100, 3);
    repeat (3) tick();
    check("pre_rst_valid", evt.evt_valid, 1);
    check("pre_rst_id", evt.evt_id, 2);
    press(3'b001, 2);
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", evt.evt_valid, 0);
    check("async_rst_id", evt.evt_id, 0);
    check("async_rst_ocupado", ocupado, 0);
    exp_q.delete();
    model_rr = N - 1;
    repeat (2) tick();
    rst_n = 1'b1;
    evt.evt_ready = 1'b1;
    repeat (30) tick();
    check("no_stale_valid", evt.evt_valid, 0);

    // Service resumes normally after reset
    push_events(3'b010, 1'b0);
    press(3'b010, 4);
    wait_drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
